if_prefetch: RTL and testbench
==============================

IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 SHALL have parameter OUTSTANDING, default 2, meaning max in-flight instruction requests (1..4).
REQ-002 SHALL have parameter IBUF_DEPTH, default 4, meaning instruction buffer entries (power of 2, 2..8).
REQ-003 SHALL have parameter RESET_PC, default 32'hbfc00000, meaning first fetch address.
REQ-004 SHALL have parameter EXC_PC, default 32'hbfc00380, meaning exception entry address.
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 resetn  in  1  reset, asynchronous, active-low.
REQ-007 ds_allowin  in  1  decode accepts an entry this cycle.
REQ-008 br_taken  in  1  single-cycle branch redirect pulse; br_target  in  32  its target.
REQ-009 wb_exc  in  1  exception flush pulse; wb_eret  in  1  eret flush pulse; eret_pc  in  32  eret target.
REQ-010 fs_to_ds_valid  out  1  buffer head valid.
REQ-011 fs_to_ds_pc  out  32 / fs_to_ds_inst  out  32 / fs_to_ds_adel  out  1  head pc, instruction, fetch-address-error flag.
REQ-012 inst_sram_req  out  1 / inst_sram_wr  out  1 / inst_sram_size  out  2 / inst_sram_addr  out  32 / inst_sram_wdata  out  32  request channel.
REQ-013 inst_sram_rdata  in  32 / inst_sram_addr_ok  in  1 / inst_sram_data_ok  in  1  response channel; responses return in request order.

Function
REQ-014 inst_sram_wr SHALL be 0, inst_sram_size 2'd2, inst_sram_wdata 0, constantly.
REQ-015 Counters: live (in flight, to be kept), cancel (in flight, to be discarded), cnt (buffer occupancy); total = live+cancel.
REQ-016 inst_sram_req SHALL rise when total<OUTSTANDING, live+cnt<IBUF_DEPTH, fetch_pc[1:0]==0, and no adel entry pending.
REQ-017 Once req is high SHALL hold req and inst_sram_addr stable until addr_ok, regardless of redirect or flush.
REQ-018 req&&addr_ok SHALL advance fetch_pc by 4 (wrap mod 2^32), push issuing pc into an OUTSTANDING-deep pc queue, increment live (or cancel, see REQ-022).
REQ-019 data_ok with cancel>0 SHALL discard data, pop pc queue, decrement cancel; otherwise SHALL push {pc,rdata,adel=0} into buffer, pop pc queue, decrement live.
REQ-020 fetch_pc misaligned: no request; SHALL push one entry {pc,inst=0,adel=1} once live==0 and buffer not full, then issue nothing until redirect.
REQ-021 Redirect priority wb_exc > wb_eret > br_taken; target EXC_PC, eret_pc, br_target respectively.
REQ-022 On redirect: buffer emptied, cancel<=total (including a same-cycle addr_ok, excluding a same-cycle data_ok), live<=0; if req held without addr_ok, target latched in pending register, fetch_pc takes it on that addr_ok, and that request counts as cancel; else fetch_pc<=target next cycle.
REQ-023 Redirect during an outstanding pending target SHALL overwrite pending target (latest wins).
REQ-024 fs_to_ds_valid SHALL equal cnt!=0; pop when valid&&ds_allowin; push and pop same cycle keep cnt; flush overrides both.
REQ-025 Buffer full: no data loss guaranteed by REQ-016 credit rule; data_ok at full is impossible by construction and needs no handling.
REQ-026 Latency: addr_ok at cycle N, data_ok at cycle M -> entry visible on fs_to_ds at M+1.

Reset
REQ-027 resetn low SHALL force: fetch_pc=RESET_PC, live=cancel=cnt=0, pending cleared, inst_sram_req=0, fs_to_ds_valid=0, fs_to_ds_pc/inst=0, adel=0.
REQ-028 Reset asserted mid-transaction SHALL drop all in-flight bookkeeping; first req SHALL appear the cycle after resetn rises, addr RESET_PC.

Verification
REQ-029 Stream: addr_ok and data_ok every cycle (1-cycle latency), ds_allowin=1 -> pcs bfc00000, bfc00004, bfc00008 appear on consecutive cycles, never more than OUTSTANDING in flight.
REQ-030 Backpressure: ds_allowin=0 with IBUF_DEPTH=4 -> exactly 4 entries buffered, req low, release -> entries drain in order, no loss or duplicate.
REQ-031 Branch with 2 in flight: br_taken, br_target=bfc00100 -> both responses discarded, next delivered pc bfc00100.
REQ-032 Redirect while req held without addr_ok: wb_exc -> addr unchanged until addr_ok, that response discarded, next delivered pc bfc00380.
REQ-033 Misaligned: br_target=bfc00102 -> one entry pc bfc00102, adel=1, inst=0, no sram req until wb_exc.
REQ-034 Simultaneous wb_exc and br_taken, plus data_ok same cycle -> target bfc00380, cancel=total-1, no stale instruction delivered.

Source files
------------

// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - instruction prefetcher: SRAM-like request channel, in-flight cancel tracking, decode buffer
module if_prefetch #(
    parameter int          OUTSTANDING = 2,
    parameter int          IBUF_DEPTH  = 4,
    parameter logic [31:0] RESET_PC    = 32'hbfc00000,
    parameter logic [31:0] EXC_PC      = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        wb_exc,
    input  logic        wb_eret,
    input  logic [31:0] eret_pc,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_to_ds_pc,
    output logic [31:0] fs_to_ds_inst,
    output logic        fs_to_ds_adel,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok
);

    localparam int         PW      = $clog2(IBUF_DEPTH);
    localparam int         QW      = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic [3:0] OUT_L   = 4'(OUTSTANDING);
    localparam logic [3:0] DEPTH_L = 4'(IBUF_DEPTH);

    logic        run;
    logic        req_hold;
    logic        pend_valid;
    logic [31:0] pend_pc;
    logic        adel_done;
    logic [31:0] fetch_pc;
    logic [3:0]  live;
    logic [3:0]  cancel;
    logic [3:0]  cnt;

    logic [31:0]           pcq [OUTSTANDING];
    logic [QW-1:0]         q_wr;
    logic [QW-1:0]         q_rd;
    logic [31:0]           buf_pc   [IBUF_DEPTH];
    logic [31:0]           buf_inst [IBUF_DEPTH];
    logic [IBUF_DEPTH-1:0] buf_adel;
    logic [PW-1:0]         b_wr;
    logic [PW-1:0]         b_rd;

    logic [3:0]  total;
    logic        redirect;
    logic [31:0] redir_pc;
    logic        can_issue;
    logic        acc;
    logic        dok_drop;
    logic        dok_keep;
    logic        adel_push;
    logic        push;
    logic        pop;
    logic [31:0] push_pc;
    logic [31:0] push_inst;

    function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
        return (p == QW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign total     = live + cancel;
    assign redirect  = wb_exc | wb_eret | br_taken;
    assign redir_pc  = wb_exc ? EXC_PC : (wb_eret ? eret_pc : br_target);

    // live+cnt bounds buffer credit, so a returning response always has a slot
    assign can_issue = (total < OUT_L) && ((live + cnt) < DEPTH_L) &&
                       (fetch_pc[1:0] == 2'b00) && !adel_done;
    assign inst_sram_req   = run && (req_hold || can_issue);
    assign inst_sram_addr  = fetch_pc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wdata = 32'h0;

    assign acc       = inst_sram_req && inst_sram_addr_ok;
    assign dok_drop  = inst_sram_data_ok && (cancel != 4'd0);
    assign dok_keep  = inst_sram_data_ok && (cancel == 4'd0);
    assign adel_push = (fetch_pc[1:0] != 2'b00) && !adel_done && (live == 4'd0) &&
                       (cnt < DEPTH_L) && !redirect;
    assign push      = (dok_keep || adel_push) && !redirect;
    assign pop       = fs_to_ds_valid && ds_allowin;
    assign push_pc   = adel_push ? fetch_pc : pcq[q_rd];
    assign push_inst = adel_push ? 32'h0 : inst_sram_rdata;

    assign fs_to_ds_valid = (cnt != 4'd0);
    assign fs_to_ds_pc    = fs_to_ds_valid ? buf_pc[b_rd]   : 32'h0;
    assign fs_to_ds_inst  = fs_to_ds_valid ? buf_inst[b_rd] : 32'h0;
    assign fs_to_ds_adel  = fs_to_ds_valid & buf_adel[b_rd];

    always_ff @(posedge clk) begin
        if (acc) begin
            pcq[q_wr] <= inst_sram_addr;
        end
        if (push) begin
            buf_pc[b_wr]   <= push_pc;
            buf_inst[b_wr] <= push_inst;
            buf_adel[b_wr] <= adel_push;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run        <= 1'b0;
            req_hold   <= 1'b0;
            pend_valid <= 1'b0;
            pend_pc    <= 32'h0;
            adel_done  <= 1'b0;
            fetch_pc   <= RESET_PC;
            live       <= 4'd0;
            cancel     <= 4'd0;
            cnt        <= 4'd0;
            q_wr       <= '0;
            q_rd       <= '0;
            b_wr       <= '0;
            b_rd       <= '0;
        end else begin
            run      <= 1'b1;
            req_hold <= inst_sram_req && !inst_sram_addr_ok;
            if (acc) begin
                q_wr <= q_inc(q_wr);
            end
            if (inst_sram_data_ok) begin
                q_rd <= q_inc(q_rd);
            end
            if (redirect) begin
                live      <= 4'd0;
                cancel    <= total + {3'b0, acc} - {3'b0, inst_sram_data_ok};
                cnt       <= 4'd0;
                b_wr      <= '0;
                b_rd      <= '0;
                adel_done <= 1'b0;
                // a held request cannot change address, so the target waits for its addr_ok
                if (inst_sram_req && !inst_sram_addr_ok) begin
                    pend_valid <= 1'b1;
                    pend_pc    <= redir_pc;
                end else begin
                    pend_valid <= 1'b0;
                    fetch_pc   <= redir_pc;
                end
            end else begin
                if (acc) begin
                    if (pend_valid) begin
                        fetch_pc   <= pend_pc;
                        pend_valid <= 1'b0;
                    end else begin
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                end
                live   <= live + {3'b0, acc && !pend_valid} - {3'b0, dok_keep};
                cancel <= cancel + {3'b0, acc && pend_valid} - {3'b0, dok_drop};
                cnt    <= cnt + {3'b0, push} - {3'b0, pop};
                if (push) begin
                    b_wr <= b_wr + 1'b1;
                end
                if (pop) begin
                    b_rd <= b_rd + 1'b1;
                end
                if (adel_push) begin
                    adel_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - directed bench for if_prefetch with an in-order 1-cycle SRAM responder
module tb_if_prefetch;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ds_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic        wb_exc;
    logic        wb_eret;
    logic [31:0] eret_pc;
    logic        fs_to_ds_valid;
    logic [31:0] fs_to_ds_pc;
    logic [31:0] fs_to_ds_inst;
    logic        fs_to_ds_adel;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;

    always #5 clk = ~clk;

    if_prefetch dut (
        .clk               (clk),
        .resetn            (resetn),
        .ds_allowin        (ds_allowin),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .wb_exc            (wb_exc),
        .wb_eret           (wb_eret),
        .eret_pc           (eret_pc),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_pc       (fs_to_ds_pc),
        .fs_to_ds_inst     (fs_to_ds_inst),
        .fs_to_ds_adel     (fs_to_ds_adel),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_rdata   (inst_sram_rdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    bit          ok_en;
    bit          dok_en;
    logic [31:0] mq [$];
    logic [31:0] got_pc [$];
    logic [31:0] got_inst [$];
    logic        got_adel [$];
    int          got_cyc [$];
    int          cyc = 0;
    int          max_inflight = 0;
    int          req_seen = 0;
    int          base;
    int          errs;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // memory returns ~addr as the instruction word, in request order, one cycle after acceptance
    task automatic step();
        logic        acc;
        logic        dok;
        logic [31:0] a;
        @(negedge clk);
        inst_sram_addr_ok = ok_en & inst_sram_req;
        inst_sram_data_ok = dok_en && (mq.size() > 0);
        inst_sram_rdata   = (mq.size() > 0) ? ~mq[0] : 32'h0;
        #1;
        if (fs_to_ds_valid && ds_allowin) begin
            got_pc.push_back(fs_to_ds_pc);
            got_inst.push_back(fs_to_ds_inst);
            got_adel.push_back(fs_to_ds_adel);
            got_cyc.push_back(cyc);
        end
        if (inst_sram_req) req_seen++;
        acc = inst_sram_req & inst_sram_addr_ok;
        dok = inst_sram_data_ok;
        a   = inst_sram_addr;
        @(posedge clk);
        if (dok) void'(mq.pop_front());
        if (acc) mq.push_back(a);
        if (mq.size() > max_inflight) max_inflight = mq.size();
        cyc++;
        #1;
    endtask

    task automatic wait_deliver(input int n, input string tag);
        int b = 0;
        while (got_pc.size() < n && b < 50) begin
            step();
            b++;
        end
        if (got_pc.size() < n) expect_eq(tag, 32'(got_pc.size()), 32'(n));
    endtask

    task automatic fill_two(input string tag);
        int b = 0;
        while (mq.size() < 2 && b < 10) begin
            step();
            b++;
        end
        if (mq.size() < 2) expect_eq(tag, 32'(mq.size()), 32'd2);
    endtask

    initial begin
        resetn = 1'b0; ds_allowin = 1'b1; br_taken = 1'b0; br_target = 32'h0;
        wb_exc = 1'b0; wb_eret = 1'b0; eret_pc = 32'h0;
        inst_sram_rdata = 32'h0; inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0;
        ok_en = 1'b1; dok_en = 1'b1;

        repeat (3) step();
        expect_eq("rst_req",   32'(inst_sram_req),  32'd0);
        expect_eq("rst_valid", 32'(fs_to_ds_valid), 32'd0);
        expect_eq("rst_pc",    fs_to_ds_pc,         32'h0);
        expect_eq("rst_adel",  32'(fs_to_ds_adel),  32'd0);
        expect_eq("const_chan", {29'h0, inst_sram_wr, inst_sram_size} | inst_sram_wdata, 32'd2);

        resetn = 1'b1;
        #1;
        expect_eq("rel_req_low", 32'(inst_sram_req), 32'd0);
        step();
        expect_eq("first_req",  32'(inst_sram_req), 32'd1);
        expect_eq("first_addr", inst_sram_addr,     32'hbfc00000);

        // continuous stream
        repeat (8) step();
        expect_eq("stream_pc0",   got_pc[0],   32'hbfc00000);
        expect_eq("stream_pc1",   got_pc[1],   32'hbfc00004);
        expect_eq("stream_pc2",   got_pc[2],   32'hbfc00008);
        expect_eq("stream_inst0", got_inst[0], 32'h403fffff);
        expect_eq("stream_adel0", 32'(got_adel[0]), 32'd0);
        expect_eq("stream_gap01", 32'(got_cyc[1] - got_cyc[0]), 32'd1);
        expect_eq("stream_gap12", 32'(got_cyc[2] - got_cyc[1]), 32'd1);

        // backpressure fills exactly IBUF_DEPTH entries
        ds_allowin = 1'b0;
        repeat (12) step();
        expect_eq("full_valid", 32'(fs_to_ds_valid), 32'd1);
        expect_eq("full_req",   32'(inst_sram_req),  32'd0);
        ok_en = 1'b0;
        base = got_pc.size();
        ds_allowin = 1'b1;
        repeat (6) step();
        expect_eq("drain_count", 32'(got_pc.size() - base), 32'd4);
        expect_eq("drain_empty", 32'(fs_to_ds_valid), 32'd0);
        errs = 0;
        for (int i = 0; i < got_pc.size(); i++) begin
            if (got_pc[i] !== 32'hbfc00000 + 32'(4 * i) || got_inst[i] !== ~(32'hbfc00000 + 32'(4 * i)))
                errs++;
        end
        expect_eq("order_no_loss", 32'(errs), 32'd0);

        // exception while the request is held without addr_ok
        expect_eq("held_req0",  32'(inst_sram_req), 32'd1);
        expect_eq("held_addr0", inst_sram_addr, 32'hbfc00000 + 32'(4 * got_pc.size()));
        wb_exc = 1'b1;
        step();
        wb_exc = 1'b0;
        repeat (2) step();
        expect_eq("held_req",  32'(inst_sram_req), 32'd1);
        expect_eq("held_addr", inst_sram_addr, 32'hbfc00000 + 32'(4 * got_pc.size()));
        ok_en = 1'b1;
        step();
        expect_eq("exc_addr", inst_sram_addr, 32'hbfc00380);
        base = got_pc.size();
        wait_deliver(base + 1, "exc_timeout");
        expect_eq("exc_pc",   got_pc[base],   32'hbfc00380);
        expect_eq("exc_inst", got_inst[base], 32'h403ffc7f);

        // branch with two requests in flight
        dok_en = 1'b0;
        fill_two("br_fill_timeout");
        repeat (5) step();
        br_target = 32'hbfc00100;
        br_taken = 1'b1;
        step();
        br_taken = 1'b0;
        dok_en = 1'b1;
        base = got_pc.size();
        wait_deliver(base + 1, "br_timeout");
        expect_eq("br_pc",   got_pc[base],   32'hbfc00100);
        expect_eq("br_inst", got_inst[base], 32'h403ffeff);

        // misaligned branch target
        br_target = 32'hbfc00102;
        br_taken = 1'b1;
        step();
        br_taken = 1'b0;
        base = got_pc.size();
        req_seen = 0;
        repeat (8) step();
        expect_eq("adel_count", 32'(got_pc.size() - base), 32'd1);
        expect_eq("adel_pc",    got_pc[base],   32'hbfc00102);
        expect_eq("adel_inst",  got_inst[base], 32'h0);
        expect_eq("adel_flag",  32'(got_adel[base]), 32'd1);
        expect_eq("adel_noreq", 32'(req_seen), 32'd0);
        wb_exc = 1'b1;
        step();
        wb_exc = 1'b0;
        base = got_pc.size();
        wait_deliver(base + 1, "adel_exit_timeout");
        expect_eq("adel_exit_pc",   got_pc[base], 32'hbfc00380);
        expect_eq("adel_exit_flag", 32'(got_adel[base]), 32'd0);

        // wb_exc and br_taken together, with a data_ok in the same cycle
        dok_en = 1'b0;
        fill_two("pri_fill_timeout");
        repeat (5) step();
        wb_exc = 1'b1;
        br_taken = 1'b1;
        br_target = 32'hbfc00200;
        dok_en = 1'b1;
        step();
        wb_exc = 1'b0;
        br_taken = 1'b0;
        base = got_pc.size();
        wait_deliver(base + 1, "pri_timeout");
        expect_eq("pri_pc",   got_pc[base],   32'hbfc00380);
        expect_eq("pri_inst", got_inst[base], 32'h403ffc7f);

        // eret redirect
        eret_pc = 32'hbfc01000;
        wb_eret = 1'b1;
        step();
        wb_eret = 1'b0;
        base = got_pc.size();
        wait_deliver(base + 1, "eret_timeout");
        expect_eq("eret_pc",   got_pc[base],   32'hbfc01000);
        expect_eq("eret_inst", got_inst[base], 32'h403fefff);

        // reset in the middle of traffic
        repeat (3) step();
        resetn = 1'b0;
        mq.delete();
        #1;
        expect_eq("midrst_req",   32'(inst_sram_req),  32'd0);
        expect_eq("midrst_valid", 32'(fs_to_ds_valid), 32'd0);
        expect_eq("midrst_pc",    fs_to_ds_pc,         32'h0);
        repeat (2) step();
        resetn = 1'b1;
        step();
        expect_eq("midrst_req1",  32'(inst_sram_req), 32'd1);
        expect_eq("midrst_addr1", inst_sram_addr,     32'hbfc00000);
        base = got_pc.size();
        wait_deliver(base + 1, "midrst_timeout");
        expect_eq("midrst_pc0", got_pc[base], 32'hbfc00000);

        expect_eq("max_inflight", 32'(max_inflight), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
